lstm_gate_sched: RTL and testbench

- Arbiter and sequencer that shares one dot_prod matrix-vector engine between NGATE gate requesters of an LSTM cell (input, forget, cell, output).
- Grants the engine round-robin, selects the granted gate's weight bank and restarts the engine by pulsing its synchronous reset.
- Waits for the engine's dataReadyF pulse, then captures the result vector and returns it to the requester with a one-cycle done strobe.

---
 rtl/lstm_gate_sched_if.sv | 32 +++
 rtl/lstm_gate_sched.sv | 136 +++++++++++++
 tb/tb_lstm_gate_sched.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/lstm_gate_sched_if.sv
// Request/result and engine-control bundle between the LSTM gate requesters, the
// shared dot_prod engine and lstm_gate_sched; slave modport is the scheduler side.
interface lstm_gate_sched_if #(
    parameter int NGATE    = 4,
    parameter int NROW     = 16,
    parameter int BITWIDTH = 18
);
    localparam int SW = $clog2(NGATE);
    localparam int VW = NROW * BITWIDTH;

    logic [NGATE-1:0] req;
    logic [NGATE-1:0] grant;
    logic [SW-1:0]    gate_sel;
    logic             eng_reset;
    logic             eng_ready;
    logic [VW-1:0]    eng_vector;
    logic [NGATE-1:0] done;
    logic [VW-1:0]    res_data;
    logic [SW-1:0]    res_gate;
    logic             busy;
    logic             err;

    modport master (
        output req, eng_ready, eng_vector,
        input  grant, gate_sel, eng_reset, done, res_data, res_gate, busy, err
    );

    modport slave (
        input  req, eng_ready, eng_vector,
        output grant, gate_sel, eng_reset, done, res_data, res_gate, busy, err
    );
endinterface

// File: rtl/lstm_gate_sched.sv
// Round-robin owner of the shared dot_prod engine: grant, restart engine, capture result, strobe done.
// Latency: req->grant 1, grant->eng_reset low ENG_RST_CYC, eng_ready->done 1 cycle.
// Backpressure: req is level-held until done; optional RUN watchdog under LSTM_SCHED_TIMEOUT_EN.
module lstm_gate_sched #(
    parameter int NGATE       = 4,
    parameter int NROW        = 16,
    parameter int BITWIDTH    = 18,
    parameter int ENG_RST_CYC = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic              clk,
    input  logic              reset,
    lstm_gate_sched_if.slave  bus
);
    localparam int SW = $clog2(NGATE);
    localparam int VW = NROW * BITWIDTH;
    localparam int RW = $clog2(ENG_RST_CYC) + 1;
    localparam logic [NGATE-1:0] ONE = NGATE'(1);

    typedef enum logic [1:0] {IDLE, RST, RUN, DONE} state_t;

    state_t           state;
    logic [SW-1:0]    rr_ptr;
    logic [RW-1:0]    rst_cnt;
    logic [NGATE-1:0] grant_q;
    logic [SW-1:0]    gate_sel_q;
    logic             eng_reset_q;
    logic [NGATE-1:0] done_q;
    logic [VW-1:0]    res_data_q;
    logic [SW-1:0]    res_gate_q;
    logic             busy_q;
    logic             timed_out;

    logic [SW-1:0]    pick;
    logic [SW-1:0]    idx;

    // Scan from the farthest offset down so the nearest requester at/after rr_ptr wins.
    always_comb begin
        pick = rr_ptr;
        idx  = '0;
        for (int i = NGATE - 1; i >= 0; i--) begin
            idx = rr_ptr + SW'(i);
            if (bus.req[idx]) pick = idx;
        end
    end

`ifdef LSTM_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT) + 1;
    logic [TW-1:0] to_cnt;
    logic          err_q;

    assign timed_out = (to_cnt == TW'(TIMEOUT - 1));

    // Held at zero outside RUN, so it restarts from zero on every RUN entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            to_cnt <= (state == RUN) ? to_cnt + TW'(1) : '0;
            if (state == RUN && !bus.eng_ready && timed_out) err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign timed_out = 1'b0;
    assign bus.err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            rst_cnt     <= '0;
            grant_q     <= '0;
            gate_sel_q  <= '0;
            eng_reset_q <= 1'b1;
            done_q      <= '0;
            res_data_q  <= '0;
            res_gate_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            done_q <= '0;
            case (state)
                IDLE: begin
                    eng_reset_q <= 1'b1;
                    if (|bus.req) begin
                        grant_q    <= ONE << pick;
                        gate_sel_q <= pick;
                        rst_cnt    <= '0;
                        busy_q     <= 1'b1;
                        state      <= RST;
                    end
                end
                RST: begin
                    if (rst_cnt == RW'(ENG_RST_CYC - 1)) begin
                        eng_reset_q <= 1'b0;
                        state       <= RUN;
                    end else begin
                        rst_cnt <= rst_cnt + RW'(1);
                    end
                end
                RUN: begin
                    if (bus.eng_ready) begin
                        res_data_q  <= bus.eng_vector;
                        res_gate_q  <= gate_sel_q;
                        done_q      <= ONE << gate_sel_q;
                        eng_reset_q <= 1'b1;
                        state       <= DONE;
                    end else if (timed_out) begin
                        // Abandon the job without touching the captured result.
                        done_q      <= ONE << gate_sel_q;
                        eng_reset_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    grant_q <= '0;
                    rr_ptr  <= gate_sel_q + SW'(1);
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant     = grant_q;
    assign bus.gate_sel  = gate_sel_q;
    assign bus.eng_reset = eng_reset_q;
    assign bus.done      = done_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_gate  = res_gate_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_lstm_gate_sched.sv
// Directed + randomized bench for lstm_gate_sched; the engine is played inline and a
// round-robin reference (pointer + served-gate bookkeeping) predicts every grant and result.
module tb_lstm_gate_sched;
    localparam int NGATE       = 4;
    localparam int NROW        = 16;
    localparam int BITWIDTH    = 18;
    localparam int ENG_RST_CYC = 2;
    localparam int TOUT        = 16;
    localparam int W           = NROW * BITWIDTH;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    int           rr;
    logic [W-1:0] last_res;

    lstm_gate_sched_if #(.NGATE(NGATE), .NROW(NROW), .BITWIDTH(BITWIDTH)) bus ();

    lstm_gate_sched #(
        .NGATE(NGATE), .NROW(NROW), .BITWIDTH(BITWIDTH),
        .ENG_RST_CYC(ENG_RST_CYC), .TIMEOUT(TOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed hang expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < (W + 31) / 32; i++) v = (v << 32) | W'($urandom());
        return v;
    endfunction

    // Reference arbitration: first requester at or after the pointer, modulo NGATE.
    function automatic int pick_gate(input logic [NGATE-1:0] r, input int p);
        for (int k = 0; k < NGATE; k++)
            if (r[(p + k) % NGATE]) return (p + k) % NGATE;
        return -1;
    endfunction

    // Starts at a negedge in IDLE with req applied; ends at the negedge of the following IDLE.
    task automatic job(input int lat, input bit drop, input bit keep, input bit stray);
        int           g;
        logic [W-1:0] v;
        g = pick_gate(bus.req, rr);
        tick();
        chk("grant", W'(bus.grant), W'(1 << g));
        chk("gate_sel", W'(bus.gate_sel), W'(g));
        chk("busy_job", W'(bus.busy), W'(1));
        for (int i = 0; i < ENG_RST_CYC; i++) begin
            chk("eng_reset_hi", W'(bus.eng_reset), W'(1));
            if (stray && i == 0) begin
                bus.eng_ready  = 1'b1;
                bus.eng_vector = rand_vec();
            end
            tick();
            bus.eng_ready = 1'b0;
        end
        chk("eng_reset_lo", W'(bus.eng_reset), W'(0));
        chk("no_early_capture", bus.res_data, last_res);
        chk("no_early_done", W'(bus.done), W'(0));
        if (drop) bus.req[g] = 1'b0;
        repeat (lat) tick();
        chk("grant_run", W'(bus.grant), W'(1 << g));
        v = rand_vec();
        bus.eng_vector = v;
        bus.eng_ready  = 1'b1;
        tick();
        bus.eng_ready  = 1'b0;
        bus.eng_vector = rand_vec();
        chk("done", W'(bus.done), W'(1 << g));
        chk("res_data", bus.res_data, v);
        chk("res_gate", W'(bus.res_gate), W'(g));
        chk("eng_reset_done", W'(bus.eng_reset), W'(1));
        last_res = v;
        rr = (g + 1) % NGATE;
        if (!keep) bus.req[g] = 1'b0;
        tick();
        chk("done_clear", W'(bus.done), W'(0));
        chk("grant_clear", W'(bus.grant), W'(0));
        chk("busy_idle", W'(bus.busy), W'(0));
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        rr             = 0;
        last_res       = '0;
        reset          = 1'b0;
        bus.req        = '0;
        bus.eng_ready  = 1'b0;
        bus.eng_vector = '0;
        repeat (3) @(negedge clk);

        chk("rst_grant", W'(bus.grant), W'(0));
        chk("rst_gate_sel", W'(bus.gate_sel), W'(0));
        chk("rst_eng_reset", W'(bus.eng_reset), W'(1));
        chk("rst_done", W'(bus.done), W'(0));
        chk("rst_res_data", bus.res_data, W'(0));
        chk("rst_res_gate", W'(bus.res_gate), W'(0));
        chk("rst_busy", W'(bus.busy), W'(0));
        chk("rst_err", W'(bus.err), W'(0));
        reset = 1'b1;
        tick();

        // Single request with a 20-cycle engine
        bus.req = NGATE'(1);
        job(20, 1'b0, 1'b0, 1'b0);

        // Stray ready while idle
        bus.eng_ready  = 1'b1;
        bus.eng_vector = rand_vec();
        tick();
        bus.eng_ready = 1'b0;
        chk("stray_idle_done", W'(bus.done), W'(0));
        chk("stray_idle_data", bus.res_data, last_res);
        chk("stray_idle_busy", W'(bus.busy), W'(0));

        // All gates requesting continuously
        bus.req = '1;
        for (int n = 0; n < 5; n++) job($urandom_range(0, 6), 1'b0, 1'b1, 1'b0);
        bus.req = '0;

        // Request withdrawn in RUN, plus a stray ready during RST
        bus.req = NGATE'(4);
        job(5, 1'b1, 1'b0, 1'b1);
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("no_regrant", W'(bus.grant), W'(0));
        end

        // Random request mixes; unserved requests stay pending
        for (int n = 0; n < 12; n++) begin
            bus.req = bus.req | NGATE'($urandom_range(1, (1 << NGATE) - 1));
            job($urandom_range(0, 8), 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
        end
        for (int n = 0; n < NGATE; n++)
            if (bus.req != '0) job($urandom_range(0, 4), 1'b0, 1'b0, 1'b0);
        chk("drained", W'(bus.req), W'(0));

        // Async reset in the middle of gate 2's RUN
        bus.req = NGATE'(4);
        tick();
        chk("mid_grant", W'(bus.grant), W'(4));
        repeat (ENG_RST_CYC) tick();
        repeat (3) tick();
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_grant", W'(bus.grant), W'(0));
        chk("mid_rst_eng_reset", W'(bus.eng_reset), W'(1));
        chk("mid_rst_busy", W'(bus.busy), W'(0));
        chk("mid_rst_done", W'(bus.done), W'(0));
        @(negedge clk);
        reset    = 1'b1;
        bus.req  = '0;
        rr       = 0;
        last_res = '0;
        chk("mid_rst_res_data", bus.res_data, W'(0));
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("mid_rst_no_done", W'(bus.done), W'(0));
        end
        bus.req = NGATE'(4);
        job(7, 1'b0, 1'b0, 1'b0);

`ifdef LSTM_SCHED_TIMEOUT_EN
        bus.req = NGATE'(1);
        tick();
        chk("to_grant", W'(bus.grant), W'(1));
        repeat (ENG_RST_CYC) tick();
        chk("to_run", W'(bus.eng_reset), W'(0));
        repeat (TOUT - 1) tick();
        chk("to_not_yet", W'(bus.done), W'(0));
        tick();
        chk("to_done", W'(bus.done), W'(1));
        chk("to_err", W'(bus.err), W'(1));
        chk("to_res_data", bus.res_data, last_res);
        bus.req = '0;
        rr      = 1;
        repeat (3) tick();
        chk("to_err_sticky", W'(bus.err), W'(1));
        chk("to_idle", W'(bus.busy), W'(0));
`else
        chk("err_tied", W'(bus.err), W'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
